// File: rtl/stage2_decode_hazard.sv
// Decode stage between fetch and execute.
// Decodes the RV32I base opcodes, reads the register file with optional
// writeback bypass, stalls on load-use hazards, and presents the result
// through one registered valid/ready output slot.
module stage2_decode_hazard #(
    parameter int   WIDTH          = 32,
    parameter int   REGISTER_DEPTH = 32,
    parameter int   ENABLE_BYPASS  = 1,
    localparam int  AW             = $clog2(REGISTER_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instruction,
    input  logic [WIDTH-1:0] in_pc,
    input  logic             in_branch_pred,
    output logic [AW-1:0]    rf_addr_1,
    output logic [AW-1:0]    rf_addr_2,
    input  logic [WIDTH-1:0] rf_data_1,
    input  logic [WIDTH-1:0] rf_data_2,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             ex_load_valid,
    input  logic [AW-1:0]    ex_load_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic [6:0]       out_opcode,
    output logic [AW-1:0]    out_rd,
    output logic [AW-1:0]    out_rs1,
    output logic [AW-1:0]    out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [WIDTH-1:0] out_immediate,
    output logic [WIDTH-1:0] out_rs1_value,
    output logic [WIDTH-1:0] out_rs2_value,
    output logic             out_branch_pred,
    output logic             out_illegal
);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    logic [6:0]         opcode;
    logic [AW-1:0]      dec_rd;
    logic [AW-1:0]      dec_rs1;
    logic [AW-1:0]      dec_rs2;
    logic [2:0]         dec_funct3;
    logic [6:0]         dec_funct7;
    logic signed [31:0] dec_imm32;
    logic               use_rs1;
    logic               use_rs2;
    logic               dec_illegal;
    logic               stall;
    logic               slot_free;
    logic               transfer;
    logic [WIDTH-1:0]   op_value_1;
    logic [WIDTH-1:0]   op_value_2;

    // Operand value: zero for x0 or an unused source, else the bypassed
    // writeback value when it targets this register, else register-file data.
    function automatic logic [WIDTH-1:0] operand_select(
        input logic             used,
        input logic [AW-1:0]    addr,
        input logic [WIDTH-1:0] rf_value,
        input logic             wb_en,
        input logic [AW-1:0]    wb_addr,
        input logic [WIDTH-1:0] wb_value
    );
        if (!used || addr == '0)
            return '0;
        if (ENABLE_BYPASS != 0 && wb_en && wb_addr == addr)
            return wb_value;
        return rf_value;
    endfunction

    assign opcode = in_instruction[6:0];

    // Combinational field and immediate decode, per instruction format.
    always_comb begin
        dec_rd      = '0;
        dec_rs1     = '0;
        dec_rs2     = '0;
        dec_funct3  = '0;
        dec_funct7  = '0;
        dec_imm32   = '0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                dec_rd     = AW'(in_instruction[11:7]);
                dec_rs1    = AW'(in_instruction[19:15]);
                dec_funct3 = in_instruction[14:12];
                dec_imm32  = {{20{in_instruction[31]}}, in_instruction[31:20]};
                use_rs1    = 1'b1;
            end
            OPC_OP: begin
                dec_rd     = AW'(in_instruction[11:7]);
                dec_rs1    = AW'(in_instruction[19:15]);
                dec_rs2    = AW'(in_instruction[24:20]);
                dec_funct3 = in_instruction[14:12];
                dec_funct7 = in_instruction[31:25];
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OPC_STORE: begin
                dec_rs1    = AW'(in_instruction[19:15]);
                dec_rs2    = AW'(in_instruction[24:20]);
                dec_funct3 = in_instruction[14:12];
                dec_imm32  = {{20{in_instruction[31]}}, in_instruction[31:25],
                              in_instruction[11:7]};
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OPC_BRANCH: begin
                dec_rs1    = AW'(in_instruction[19:15]);
                dec_rs2    = AW'(in_instruction[24:20]);
                dec_funct3 = in_instruction[14:12];
                dec_imm32  = {{19{in_instruction[31]}}, in_instruction[31],
                              in_instruction[7], in_instruction[30:25],
                              in_instruction[11:8], 1'b0};
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_rd    = AW'(in_instruction[11:7]);
                dec_imm32 = {in_instruction[31:12], 12'b0};
            end
            OPC_JAL: begin
                dec_rd    = AW'(in_instruction[11:7]);
                dec_imm32 = {{11{in_instruction[31]}}, in_instruction[31],
                             in_instruction[19:12], in_instruction[20],
                             in_instruction[30:21], 1'b0};
            end
            OPC_SYSTEM, OPC_MISC_MEM: begin
                // I-format fields are reported, but no register is read.
                dec_rd     = AW'(in_instruction[11:7]);
                dec_rs1    = AW'(in_instruction[19:15]);
                dec_funct3 = in_instruction[14:12];
                dec_imm32  = {{20{in_instruction[31]}}, in_instruction[31:20]};
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    assign rf_addr_1 = use_rs1 ? dec_rs1 : '0;
    assign rf_addr_2 = use_rs2 ? dec_rs2 : '0;

    assign op_value_1 = operand_select(use_rs1, dec_rs1, rf_data_1, wb_valid, wb_rd, wb_data);
    assign op_value_2 = operand_select(use_rs2, dec_rs2, rf_data_2, wb_valid, wb_rd, wb_data);

    // A load in execute whose destination feeds this instruction cannot be
    // forwarded in time, so the instruction is held back for a cycle.
    assign stall = in_valid && ex_load_valid && (ex_load_rd != '0) &&
                   ((use_rs1 && dec_rs1 == ex_load_rd) ||
                    (use_rs2 && dec_rs2 == ex_load_rd));

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = slot_free && !stall && !flush;
    assign transfer  = in_valid && in_ready;

    // Output slot: reset, flush, load, bubble, or hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_pc          <= '0;
            out_opcode      <= '0;
            out_rd          <= '0;
            out_rs1         <= '0;
            out_rs2         <= '0;
            out_funct3      <= '0;
            out_funct7      <= '0;
            out_immediate   <= '0;
            out_rs1_value   <= '0;
            out_rs2_value   <= '0;
            out_branch_pred <= 1'b0;
            out_illegal     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (transfer) begin
            out_valid       <= 1'b1;
            out_pc          <= in_pc;
            out_opcode      <= opcode;
            out_rd          <= dec_rd;
            out_rs1         <= dec_rs1;
            out_rs2         <= dec_rs2;
            out_funct3      <= dec_funct3;
            out_funct7      <= dec_funct7;
            out_immediate   <= WIDTH'(dec_imm32);
            out_rs1_value   <= op_value_1;
            out_rs2_value   <= op_value_2;
            out_branch_pred <= in_branch_pred;
            out_illegal     <= dec_illegal;
        end else if (slot_free) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stage2_decode_hazard.sv
// Self-checking bench for stage2_decode_hazard: directed cases followed by
// randomized traffic compared against a format-level reference model.
module tb_stage2_decode_hazard;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_branch_pred;
    logic [31:0] in_instruction, in_pc;
    logic        wb_valid, ex_load_valid, out_ready;
    logic [4:0]  wb_rd, ex_load_rd;
    logic [31:0] wb_data;

    logic        in_ready, out_valid, out_branch_pred, out_illegal;
    logic [4:0]  rf_addr_1, rf_addr_2, out_rd, out_rs1, out_rs2;
    logic [31:0] rf_data_1, rf_data_2, out_pc, out_immediate, out_rs1_value, out_rs2_value;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3;

    logic        nb_in_ready, nb_out_valid, nb_out_branch_pred, nb_out_illegal;
    logic [4:0]  nb_rf_addr_1, nb_rf_addr_2, nb_out_rd, nb_out_rs1, nb_out_rs2;
    logic [31:0] nb_rf_data_1, nb_rf_data_2, nb_out_pc, nb_out_immediate;
    logic [31:0] nb_out_rs1_value, nb_out_rs2_value;
    logic [6:0]  nb_out_opcode, nb_out_funct7;
    logic [2:0]  nb_out_funct3;

    logic [31:0] rf_mem [32];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign rf_data_1    = rf_mem[rf_addr_1];
    assign rf_data_2    = rf_mem[rf_addr_2];
    assign nb_rf_data_1 = rf_mem[nb_rf_addr_1];
    assign nb_rf_data_2 = rf_mem[nb_rf_addr_2];

    stage2_decode_hazard dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc), .in_branch_pred(in_branch_pred),
        .rf_addr_1(rf_addr_1), .rf_addr_2(rf_addr_2), .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_immediate(out_immediate), .out_rs1_value(out_rs1_value),
        .out_rs2_value(out_rs2_value), .out_branch_pred(out_branch_pred), .out_illegal(out_illegal)
    );

    stage2_decode_hazard #(.ENABLE_BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(nb_in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc), .in_branch_pred(in_branch_pred),
        .rf_addr_1(nb_rf_addr_1), .rf_addr_2(nb_rf_addr_2),
        .rf_data_1(nb_rf_data_1), .rf_data_2(nb_rf_data_2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
        .out_valid(nb_out_valid), .out_ready(out_ready), .out_pc(nb_out_pc),
        .out_opcode(nb_out_opcode), .out_rd(nb_out_rd), .out_rs1(nb_out_rs1),
        .out_rs2(nb_out_rs2), .out_funct3(nb_out_funct3), .out_funct7(nb_out_funct7),
        .out_immediate(nb_out_immediate), .out_rs1_value(nb_out_rs1_value),
        .out_rs2_value(nb_out_rs2_value), .out_branch_pred(nb_out_branch_pred),
        .out_illegal(nb_out_illegal)
    );

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        u1, u2, ill;
    } dec_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        dec_t        d;
        logic [31:0] a1, a2, n1, n2;
        logic        bp;
    } slot_t;

    slot_t m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode, written per format from the ISA encoding tables.
    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t        d;
        logic [31:0] isx;
        d    = '0;
        d.op = w[6:0];
        isx  = $signed(w) >>> 20;
        case (w[6:0])
            7'h13, 7'h03, 7'h67: begin
                d.rd = w[11:7]; d.rs1 = w[19:15]; d.f3 = w[14:12]; d.imm = isx; d.u1 = 1'b1;
            end
            7'h33: begin
                d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
                d.f3 = w[14:12]; d.f7 = w[31:25]; d.u1 = 1'b1; d.u2 = 1'b1;
            end
            7'h23: begin
                d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.f3 = w[14:12];
                d.imm = (isx & ~32'h1F) | {27'b0, w[11:7]}; d.u1 = 1'b1; d.u2 = 1'b1;
            end
            7'h63: begin
                d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.f3 = w[14:12];
                d.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                d.u1 = 1'b1; d.u2 = 1'b1;
            end
            7'h37, 7'h17: begin
                d.rd = w[11:7]; d.imm = w & 32'hFFFFF000;
            end
            7'h6F: begin
                d.rd = w[11:7];
                d.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            7'h73, 7'h0F: begin
                d.rd = w[11:7]; d.rs1 = w[19:15]; d.f3 = w[14:12]; d.imm = isx;
            end
            default: d.ill = 1'b1;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] ref_operand(input logic used, input logic [4:0] addr,
                                               input logic bypass);
        if (!used || addr == 5'd0) return 32'd0;
        if (bypass && wb_valid && wb_rd == addr) return wb_data;
        return rf_mem[addr];
    endfunction

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instruction = 32'h0; in_pc = 32'h0;
        in_branch_pred = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        ex_load_valid = 1'b0; ex_load_rd = 5'd0; out_ready = 1'b1;
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model,
    // then check the registered slot just after the edge.
    task automatic cycle();
        dec_t  d;
        logic  stall, slot_free, rdy;
        slot_t nxt;
        #3;
        d         = ref_decode(in_instruction);
        stall     = in_valid && ex_load_valid && ex_load_rd != 5'd0 &&
                    ((d.u1 && d.rs1 == ex_load_rd) || (d.u2 && d.rs2 == ex_load_rd));
        slot_free = !m.v || out_ready;
        rdy       = slot_free && !stall && !flush;
        check_eq("in_ready", 32'(in_ready), 32'(rdy));
        check_eq("nb_in_ready", 32'(nb_in_ready), 32'(rdy));
        check_eq("rf_addr_1", 32'(rf_addr_1), 32'(d.u1 ? d.rs1 : 5'd0));
        check_eq("rf_addr_2", 32'(rf_addr_2), 32'(d.u2 ? d.rs2 : 5'd0));
        nxt = m;
        if (rst) begin
            nxt.v = 1'b0; nxt.pc = '0; nxt.d = '0; nxt.a1 = '0; nxt.a2 = '0;
            nxt.n1 = '0; nxt.n2 = '0; nxt.bp = 1'b0;
        end else if (flush) begin
            nxt.v = 1'b0;
        end else if (in_valid && rdy) begin
            nxt.v  = 1'b1;
            nxt.pc = in_pc;
            nxt.d  = d;
            nxt.bp = in_branch_pred;
            nxt.a1 = ref_operand(d.u1, d.rs1, 1'b1);
            nxt.a2 = ref_operand(d.u2, d.rs2, 1'b1);
            nxt.n1 = ref_operand(d.u1, d.rs1, 1'b0);
            nxt.n2 = ref_operand(d.u2, d.rs2, 1'b0);
        end else if (slot_free) begin
            nxt.v = 1'b0;
        end
        @(posedge clk);
        #1;
        m = nxt;
        check_eq("out_valid", 32'(out_valid), 32'(m.v));
        check_eq("nb_out_valid", 32'(nb_out_valid), 32'(m.v));
        if (m.v) begin
            check_eq("out_pc", out_pc, m.pc);
            check_eq("out_opcode", 32'(out_opcode), 32'(m.d.op));
            check_eq("out_rd", 32'(out_rd), 32'(m.d.rd));
            check_eq("out_rs1", 32'(out_rs1), 32'(m.d.rs1));
            check_eq("out_rs2", 32'(out_rs2), 32'(m.d.rs2));
            check_eq("out_funct3", 32'(out_funct3), 32'(m.d.f3));
            check_eq("out_funct7", 32'(out_funct7), 32'(m.d.f7));
            check_eq("out_immediate", out_immediate, m.d.imm);
            check_eq("out_rs1_value", out_rs1_value, m.a1);
            check_eq("out_rs2_value", out_rs2_value, m.a2);
            check_eq("out_branch_pred", 32'(out_branch_pred), 32'(m.bp));
            check_eq("out_illegal", 32'(out_illegal), 32'(m.d.ill));
            check_eq("nb_rs1_value", nb_out_rs1_value, m.n1);
            check_eq("nb_rs2_value", nb_out_rs2_value, m.n2);
        end
    endtask

    logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h33, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6F, 7'h73, 7'h0F, 7'h7F};

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
        m.v = 1'b0; m.pc = '0; m.d = '0; m.a1 = '0; m.a2 = '0; m.n1 = '0; m.n2 = '0; m.bp = 1'b0;

        // Reset state
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        cycle();
        cycle();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_pc", out_pc, 32'd0);
        check_eq("rst_out_imm", out_immediate, 32'd0);
        check_eq("rst_out_rd", 32'(out_rd), 32'd0);
        check_eq("rst_out_rs1_value", out_rs1_value, 32'd0);
        check_eq("rst_out_illegal", 32'(out_illegal), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // addi x1,x0,5
        idle_inputs();
        in_valid = 1'b1; in_instruction = 32'h00500093; in_pc = 32'h40;
        cycle();
        check_eq("addi_valid", 32'(out_valid), 32'd1);
        check_eq("addi_opcode", 32'(out_opcode), 32'h13);
        check_eq("addi_rd", 32'(out_rd), 32'd1);
        check_eq("addi_rs1", 32'(out_rs1), 32'd0);
        check_eq("addi_imm", out_immediate, 32'd5);
        check_eq("addi_rs1_value", out_rs1_value, 32'd0);
        check_eq("addi_illegal", 32'(out_illegal), 32'd0);

        // add x3,x1,x2 with writeback bypass on x2
        rf_mem[1] = 32'd7; rf_mem[2] = 32'd9;
        in_instruction = 32'h002081B3; wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h55;
        cycle();
        check_eq("add_rs1_value", out_rs1_value, 32'd7);
        check_eq("add_rs2_value", out_rs2_value, 32'h55);
        check_eq("add_nb_rs2_value", nb_out_rs2_value, 32'd9);
        wb_valid = 1'b0;

        // beq x1,x2,-4 then lui x7
        in_instruction = 32'hFE208EE3;
        cycle();
        check_eq("beq_imm", out_immediate, 32'hFFFFFFFC);
        check_eq("beq_rd", 32'(out_rd), 32'd0);
        check_eq("beq_funct3", 32'(out_funct3), 32'd0);
        in_instruction = 32'h123453B7;
        cycle();
        check_eq("lui_imm", out_immediate, 32'h12345000);
        check_eq("lui_rd", 32'(out_rd), 32'd7);
        check_eq("lui_rf_addr_1", 32'(rf_addr_1), 32'd0);
        check_eq("lui_rf_addr_2", 32'(rf_addr_2), 32'd0);

        // Load-use stall on x1, release, and x0 load never stalls
        in_instruction = 32'h002081B3; ex_load_valid = 1'b1; ex_load_rd = 5'd1;
        cycle();
        check_eq("stall_in_ready", 32'(in_ready), 32'd0);
        check_eq("stall_bubble", 32'(out_valid), 32'd0);
        ex_load_valid = 1'b0;
        cycle();
        check_eq("release_valid", 32'(out_valid), 32'd1);
        check_eq("release_rd", 32'(out_rd), 32'd3);
        ex_load_valid = 1'b1; ex_load_rd = 5'd0;
        cycle();
        check_eq("x0_load_no_stall", 32'(out_valid), 32'd1);
        ex_load_valid = 1'b0;

        // Backpressure hold, then flush drops slot and pending input
        in_instruction = 32'h00500093; in_pc = 32'h100;
        cycle();
        out_ready = 1'b0; in_instruction = 32'h123453B7; in_pc = 32'h200;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_pc", out_pc, 32'h100);
            check_eq("hold_in_ready", 32'(in_ready), 32'd0);
        end
        flush = 1'b1;
        cycle();
        check_eq("flush_valid", 32'(out_valid), 32'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        check_eq("flush_dropped", 32'(out_valid), 32'd0);

        // Illegal opcode is still issued, then reset mid-stream
        in_valid = 1'b1; in_instruction = 32'hFFFFFFFF; in_pc = 32'h300;
        cycle();
        check_eq("illegal_valid", 32'(out_valid), 32'd1);
        check_eq("illegal_flag", 32'(out_illegal), 32'd1);
        check_eq("illegal_imm", out_immediate, 32'd0);
        in_instruction = 32'h00500093; rst = 1'b1;
        cycle();
        check_eq("midrst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            w = $urandom;
            w[6:0] = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 1) == 1) begin
                w[19:15] = 5'($urandom_range(0, 3));
                w[24:20] = 5'($urandom_range(0, 3));
            end
            rst            = ($urandom_range(0, 99) == 0);
            flush          = ($urandom_range(0, 19) == 0);
            in_valid       = ($urandom_range(0, 3) != 0);
            in_instruction = w;
            in_pc          = $urandom;
            in_branch_pred = 1'($urandom_range(0, 1));
            out_ready      = ($urandom_range(0, 9) < 7);
            wb_valid       = 1'($urandom_range(0, 1));
            wb_rd          = 5'($urandom_range(0, 3));
            wb_data        = $urandom;
            ex_load_valid  = ($urandom_range(0, 2) == 0);
            ex_load_rd     = 5'($urandom_range(0, 3));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
